morse_decoder_display: RTL and testbench
========================================

MORSE_DECODER_DISPLAY -- requirements
Module: morse_decoder_display

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 1000: clock cycles per Morse time unit, legal range 4..65535.
REQ-002 SHALL have parameter NUM_DIGITS, default 4: depth of the scrolling display buffer, legal range 1..8.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state is rising-edge triggered.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port key_i, input, 1: raw Morse key level (1 = pressed), asynchronous to clk_i.
REQ-006 SHALL have port ready_i, input, 1: consumer accepts the current letter.
REQ-007 SHALL have port valid_o, output, 1: letter_o/seg_o hold a decoded letter.
REQ-008 SHALL have port letter_o, output, 5: letter index 0..25 (A..Z), or 31 for an invalid code.
REQ-009 SHALL have port seg_o, output, 7: glyph of letter_o; 7'b0 when letter_o is 31.
REQ-010 SHALL have port disp_o, output, 7*NUM_DIGITS: display buffer; digit 0 (newest) occupies bits [6:0].
REQ-011 SHALL have port overrun_o, output, 1: sticky flag, set when a letter is dropped.

Function
REQ-012 SHALL pass key_i through a 2-flop synchroniser; all timing uses the synchronised level, so input-to-detection latency is 2 cycles.
REQ-013 SHALL derive a unit tick from a free-running prescaler that wraps at UNIT_CYCLES-1 and restarts at 0 on every synchronised key edge.
REQ-014 SHALL use FSM states IDLE, MARK, SPACE and EMIT.
REQ-015 SHALL move IDLE->MARK on key press, MARK->SPACE on release, SPACE->MARK on press, and SPACE->EMIT when release time reaches 3 units.
REQ-016 SHALL stay in EMIT for exactly 1 cycle, then go to IDLE.
REQ-017 SHALL classify a press shorter than 2 units as a dot (0) and a press of 2 units or more as a dash (1).
REQ-018 SHALL saturate the press and release unit counters at 7 and never wrap them.
REQ-019 SHALL shift each symbol into a 4-bit pattern (first symbol ends as the MSB of the length-aligned code) and count symbols in a 3-bit length field.
REQ-020 SHALL, on a 5th symbol, set an internal invalid flag and stop shifting further symbols.
REQ-021 SHALL, in EMIT, map {length, pattern} to a letter index using the package lookup.
REQ-022 SHALL use letter index 31 when the invalid flag is set or the code is unmapped.
REQ-023 SHALL, in EMIT, shift the glyph into disp_o digit 0 and move older digits up one position, regardless of the handshake.
REQ-024 SHALL, when IDLE release time reaches 7 units after at least one letter, shift one blank digit (7'b0) into disp_o once per gap; it SHALL NOT emit a letter for the gap.
REQ-025 SHALL raise valid_o in the cycle after EMIT and hold valid_o, letter_o and seg_o stable until a cycle with valid_o=1 and ready_i=1.
REQ-026 SHALL deassert valid_o in the cycle after the transfer when no new letter completes.
REQ-027 SHALL, when EMIT coincides with a transfer cycle, load the new letter and keep valid_o=1.
REQ-028 SHALL, when EMIT occurs with valid_o=1 and ready_i=0, drop the new letter and set overrun_o; disp_o SHALL still update.
REQ-029 SHALL keep overrun_o set until reset.
REQ-030 SHALL hold letter_o at its last value when valid_o=0.

Reset
REQ-031 SHALL, on rst_i=1, immediately clear FSM (IDLE), synchroniser, prescaler, counters, pattern, length, invalid flag, valid_o, letter_o, seg_o, disp_o and overrun_o to 0, independent of clk_i.
REQ-032 SHALL, on reset mid-letter, discard the partial symbols.
REQ-033 SHALL, after reset releases, treat a key already held as a new press only after its synchronised release and re-press.

Structure
REQ-034 SHALL define in package morse_pkg: the state enumeration, 26-entry glyph table (A=7'b1011111, E=7'b1111001, T=7'b1111000, ...), Morse code table and lookup function, DOT_MAX_UNITS=2, LETTER_GAP_UNITS=3, WORD_GAP_UNITS=7, INVALID_LETTER=31.
REQ-035 SHALL place synchroniser, prescaler and unit counters in one sub-module, morse_symbol_timer, which outputs press_done, press_is_dash and release_units.

Verification (UNIT_CYCLES=4, NUM_DIGITS=4)
REQ-036 SHALL cover: press 4 cycles, release 16 -> one valid_o, letter_o=4, seg_o=7'b1111001, disp_o[6:0]=7'b1111001.
REQ-037 SHALL cover: dot, 1-unit gap, dash (12 cycles), 3-unit gap, ready_i=1 -> letter_o=0, seg_o=7'b1011111, valid_o low next cycle.
REQ-038 SHALL cover: five dots, then gap -> letter_o=31, seg_o=7'b0, disp_o[6:0]=7'b0.
REQ-039 SHALL cover: ready_i=0, letters E then T -> valid_o held with letter_o=4, overrun_o=1, disp_o[13:0]={7'b1111001,7'b1111000}.
REQ-040 SHALL cover: E, then 8-unit release, then T -> disp_o[20:0]={E glyph, 7'b0, T glyph}.
REQ-041 SHALL cover: rst_i asserted between two symbols of a dash-dot sequence -> all outputs 0 immediately; the next letter decodes from its first symbol only.

Source files
------------

// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared types, tables and code lookup for the Morse decoder
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    localparam int DOT_MAX_UNITS    = 2;
    localparam int LETTER_GAP_UNITS = 3;
    localparam int WORD_GAP_UNITS   = 7;
    localparam logic [4:0] INVALID_LETTER = 5'd31;
    localparam logic [2:0] UNIT_SAT       = 3'd7;

    localparam logic [6:0] GLYPH_TABLE [0:25] = '{
        7'b1011111, 7'b1111100, 7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001,
        7'b0111101, 7'b1110110, 7'b0000110, 7'b0011110, 7'b1110101, 7'b0111000,
        7'b0010101, 7'b1010100, 7'b0111111, 7'b1110011, 7'b1100111, 7'b1010000,
        7'b1101101, 7'b1111000, 7'b0111110, 7'b0011100, 7'b0101010, 7'b1001001,
        7'b1101110, 7'b1011011
    };

    // {length[2:0], pattern[3:0]}; first symbol sits at bit length-1, 1 = dash
    localparam logic [6:0] CODE_TABLE [0:25] = '{
        {3'd2, 4'b0001}, {3'd4, 4'b1000}, {3'd4, 4'b1010}, {3'd3, 4'b0100},
        {3'd1, 4'b0000}, {3'd4, 4'b0010}, {3'd3, 4'b0110}, {3'd4, 4'b0000},
        {3'd2, 4'b0000}, {3'd4, 4'b0111}, {3'd3, 4'b0101}, {3'd4, 4'b0100},
        {3'd2, 4'b0011}, {3'd2, 4'b0010}, {3'd3, 4'b0111}, {3'd4, 4'b0110},
        {3'd4, 4'b1101}, {3'd3, 4'b0010}, {3'd3, 4'b0000}, {3'd1, 4'b0001},
        {3'd3, 4'b0001}, {3'd4, 4'b0001}, {3'd3, 4'b0011}, {3'd4, 4'b1001},
        {3'd4, 4'b1011}, {3'd4, 4'b1100}
    };

    function automatic logic [4:0] morse_lookup(input logic [2:0] len, input logic [3:0] pat);
        logic [4:0] idx;
        idx = INVALID_LETTER;
        for (int i = 0; i < 26; i++) begin
            if (CODE_TABLE[i] == {len, pat}) idx = 5'(i);
        end
        return idx;
    endfunction

    function automatic logic [6:0] glyph_of(input logic [4:0] letter);
        logic [6:0] g;
        g = 7'b0;
        for (int i = 0; i < 26; i++) begin
            if (letter == 5'(i)) g = GLYPH_TABLE[i];
        end
        return g;
    endfunction

endpackage

// File: rtl/morse_symbol_timer.sv
// rtl/morse_symbol_timer.sv - key synchroniser, unit prescaler and press/release unit counters
module morse_symbol_timer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic       press_start,
    output logic       press_done,
    output logic       press_is_dash,
    output logic [2:0] release_units
);

    localparam logic [15:0] WRAP = 16'(UNIT_CYCLES - 1);

    logic        sync_a;
    logic        sync_b;
    logic        key_prev;
    logic [1:0]  fill;
    logic        seen_low;
    logic [15:0] prescale;
    logic [2:0]  press_units;
    logic [2:0]  press_next;
    logic        tick;
    logic        rise;
    logic        fall;

    // A key held through reset only counts once it has been seen released
    assign rise = seen_low & sync_b & ~key_prev;
    assign fall = seen_low & ~sync_b & key_prev;
    assign tick = (prescale == WRAP);

    // Include a tick landing on the release cycle so a full N-unit press reads as N
    assign press_next    = (tick && press_units != UNIT_SAT) ? press_units + 3'd1 : press_units;
    assign press_is_dash = (press_next >= 3'(DOT_MAX_UNITS));
    assign press_start   = rise;
    assign press_done    = fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a        <= 1'b0;
            sync_b        <= 1'b0;
            key_prev      <= 1'b0;
            fill          <= 2'd0;
            seen_low      <= 1'b0;
            prescale      <= 16'd0;
            press_units   <= 3'd0;
            release_units <= 3'd0;
        end else begin
            sync_a   <= key;
            sync_b   <= sync_a;
            key_prev <= sync_b;
            if (fill != 2'd2) fill <= fill + 2'd1;
            if (fill == 2'd2 && !sync_b) seen_low <= 1'b1;

            if (rise || fall || tick) prescale <= 16'd0;
            else                      prescale <= prescale + 16'd1;

            if (rise)                      press_units <= 3'd0;
            else if (seen_low && sync_b)   press_units <= press_next;

            if (fall) begin
                release_units <= 3'd0;
            end else if (!sync_b && tick && release_units != UNIT_SAT) begin
                release_units <= release_units + 3'd1;
            end
        end
    end

endmodule

// File: rtl/morse_decoder_display.sv
// rtl/morse_decoder_display.sv - Morse key decoder with letter handshake and scrolling 7-segment buffer
module morse_decoder_display
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 1000,
    parameter int NUM_DIGITS  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    key_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [4:0]              letter_o,
    output logic [6:0]              seg_o,
    output logic [7*NUM_DIGITS-1:0] disp_o,
    output logic                    overrun_o
);

    state_t     state;
    state_t     state_next;
    logic       press_start;
    logic       press_done;
    logic       press_is_dash;
    logic [2:0] release_units;

    logic [3:0] pattern;
    logic [2:0] length;
    logic       invalid;
    logic       gap_armed;

    logic       shift_sym;
    logic       emit;
    logic       blank;
    logic [4:0] emit_letter;
    logic [6:0] emit_glyph;
    logic [7*NUM_DIGITS+6:0] disp_wide;

    morse_symbol_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk          (clk_i),
        .rst          (rst_i),
        .key          (key_i),
        .press_start  (press_start),
        .press_done   (press_done),
        .press_is_dash(press_is_dash),
        .release_units(release_units)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (press_start) state_next = ST_MARK;
            ST_MARK:  if (press_done)  state_next = ST_SPACE;
            ST_SPACE: begin
                if (press_start)                                   state_next = ST_MARK;
                else if (release_units >= 3'(LETTER_GAP_UNITS))    state_next = ST_EMIT;
            end
            ST_EMIT:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_sym = (state == ST_MARK) && press_done;
        emit      = (state == ST_EMIT);
        blank     = (state == ST_IDLE) && gap_armed && (release_units == 3'(WORD_GAP_UNITS));
    end

    always_comb begin
        emit_letter = invalid ? INVALID_LETTER : morse_lookup(length, pattern);
        emit_glyph  = (emit_letter == INVALID_LETTER) ? 7'b0 : glyph_of(emit_letter);
        disp_wide   = {disp_o, (emit ? emit_glyph : 7'b0)};
    end

    // Symbol assembly; a fifth symbol poisons the letter instead of shifting
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pattern <= 4'd0;
            length  <= 3'd0;
            invalid <= 1'b0;
        end else if (emit) begin
            pattern <= 4'd0;
            length  <= 3'd0;
            invalid <= 1'b0;
        end else if (shift_sym) begin
            if (length == 3'd4) begin
                invalid <= 1'b1;
            end else begin
                pattern <= {pattern[2:0], press_is_dash};
                length  <= length + 3'd1;
            end
        end
    end

    // Display scrolls on every letter and once per word gap, independent of the handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            disp_o    <= '0;
            gap_armed <= 1'b0;
        end else begin
            if (emit || blank) disp_o <= disp_wide[7*NUM_DIGITS-1:0];
            if (emit)          gap_armed <= 1'b1;
            else if (blank)    gap_armed <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o   <= 1'b0;
            letter_o  <= 5'd0;
            seg_o     <= 7'b0;
            overrun_o <= 1'b0;
        end else if (emit) begin
            if (!valid_o || ready_i) begin
                valid_o  <= 1'b1;
                letter_o <= emit_letter;
                seg_o    <= emit_glyph;
            end else begin
                overrun_o <= 1'b1;
            end
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_morse_decoder_display.sv
// tb/tb_morse_decoder_display.sv - directed self-checking bench for morse_decoder_display
module tb_morse_decoder_display;

    localparam logic [6:0] G_A = 7'b1011111;
    localparam logic [6:0] G_E = 7'b1111001;
    localparam logic [6:0] G_T = 7'b1111000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key = 1'b0;
    logic        ready = 1'b0;
    logic        valid;
    logic [4:0]  letter;
    logic [6:0]  seg;
    logic [27:0] disp;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    morse_decoder_display #(
        .UNIT_CYCLES(4),
        .NUM_DIGITS (4)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .key_i    (key),
        .ready_i  (ready),
        .valid_o  (valid),
        .letter_o (letter),
        .seg_o    (seg),
        .disp_o   (disp),
        .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int n);
        key = 1'b1;
        tick(n);
        key = 1'b0;
    endtask

    task automatic do_reset;
        key   = 1'b0;
        ready = 1'b0;
        rst   = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pulse_ready;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #2;
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL rst_valid got %b want 0", valid); end
        checks++; if (letter !== 5'd0)  begin errors++; $display("FAIL rst_letter got %0d want 0", letter); end
        checks++; if (seg !== 7'b0)     begin errors++; $display("FAIL rst_seg got %b want 0", seg); end
        checks++; if (disp !== 28'd0)   begin errors++; $display("FAIL rst_disp got %h want 0", disp); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", overrun); end
        tick(3);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_letter_e;
        bit ok;
        do_reset();
        press(4);
        wait_valid(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL e_valid timeout got valid=%b want 1", valid); end
        checks++; if (letter !== 5'd4) begin errors++; $display("FAIL e_letter got %0d want 4", letter); end
        checks++; if (seg !== G_E)     begin errors++; $display("FAIL e_seg got %b want %b", seg, G_E); end
        checks++; if (disp !== {21'd0, G_E}) begin errors++; $display("FAIL e_disp got %h want %h", disp, {21'd0, G_E}); end
        pulse_ready();
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL e_valid_drop got %b want 0", valid); end
    endtask

    task automatic test_letter_a;
        bit ok;
        do_reset();
        press(4);
        tick(4);
        press(12);
        wait_valid(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL a_valid timeout got valid=%b want 1", valid); end
        checks++; if (letter !== 5'd0) begin errors++; $display("FAIL a_letter got %0d want 0", letter); end
        checks++; if (seg !== G_A)     begin errors++; $display("FAIL a_seg got %b want %b", seg, G_A); end
        pulse_ready();
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL a_valid_drop got %b want 0", valid); end
        checks++; if (letter !== 5'd0) begin errors++; $display("FAIL a_letter_hold got %0d want 0", letter); end
    endtask

    task automatic test_invalid;
        bit ok;
        do_reset();
        press(4);
        wait_valid(40, ok);
        pulse_ready();
        for (int i = 0; i < 5; i++) begin
            press(4);
            tick(4);
        end
        wait_valid(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL inv_valid timeout got valid=%b want 1", valid); end
        checks++; if (letter !== 5'd31) begin errors++; $display("FAIL inv_letter got %0d want 31", letter); end
        checks++; if (seg !== 7'b0)     begin errors++; $display("FAIL inv_seg got %b want 0", seg); end
        checks++; if (disp[13:0] !== {G_E, 7'b0}) begin errors++; $display("FAIL inv_disp got %h want %h", disp[13:0], {G_E, 7'b0}); end
    endtask

    task automatic test_overrun;
        bit ok;
        do_reset();
        press(4);
        wait_valid(40, ok);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", overrun); end
        press(12);
        tick(20);
        @(negedge clk);
        checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL ovr_valid got %b want 1", valid); end
        checks++; if (letter !== 5'd4)  begin errors++; $display("FAIL ovr_letter got %0d want 4", letter); end
        checks++; if (seg !== G_E)      begin errors++; $display("FAIL ovr_seg got %b want %b", seg, G_E); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
        checks++; if (disp[13:0] !== {G_E, G_T}) begin errors++; $display("FAIL ovr_disp got %h want %h", disp[13:0], {G_E, G_T}); end
        pulse_ready();
        tick(3);
        @(negedge clk);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_word_gap;
        do_reset();
        ready = 1'b1;
        press(4);
        tick(32);
        press(12);
        tick(20);
        @(negedge clk);
        checks++; if (disp[20:0] !== {G_E, 7'b0, G_T}) begin errors++; $display("FAIL gap_disp got %h want %h", disp[20:0], {G_E, 7'b0, G_T}); end
        checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL gap_valid got %b want 0", valid); end
        checks++; if (letter !== 5'd19)  begin errors++; $display("FAIL gap_letter got %0d want 19", letter); end
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL gap_overrun got %b want 0", overrun); end
        ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset();
        press(4);
        wait_valid(40, ok);
        press(12);
        tick(4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (valid !== 1'b0)   begin errors++; $display("FAIL mid_valid got %b want 0", valid); end
        checks++; if (letter !== 5'd0)  begin errors++; $display("FAIL mid_letter got %0d want 0", letter); end
        checks++; if (seg !== 7'b0)     begin errors++; $display("FAIL mid_seg got %b want 0", seg); end
        checks++; if (disp !== 28'd0)   begin errors++; $display("FAIL mid_disp got %h want 0", disp); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun got %b want 0", overrun); end
        tick(3);
        rst = 1'b0;
        tick(2);
        press(4);
        wait_valid(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_next timeout got valid=%b want 1", valid); end
        checks++; if (letter !== 5'd4)  begin errors++; $display("FAIL mid_next_letter got %0d want 4", letter); end
    endtask

    task automatic test_held_key;
        bit ok;
        bit seen;
        key   = 1'b1;
        ready = 1'b0;
        rst   = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(12);
        key  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL held_spurious got valid=1 letter=%0d want no letter", letter); end
        tick(1);
        press(4);
        wait_valid(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL held_next timeout got valid=%b want 1", valid); end
        checks++; if (letter !== 5'd4) begin errors++; $display("FAIL held_next_letter got %0d want 4", letter); end
    endtask

    initial begin
        test_reset();
        test_letter_e();
        test_letter_a();
        test_invalid();
        test_overrun();
        test_word_gap();
        test_reset_mid();
        test_held_key();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
